// File: rtl/output_stage.sv
// Output stage: buffers one squeezed block and streams it out as WORD_W-bit words, trimming the tail to the requested message length.
// Latency: valid_out rises the cycle after output_buffer_we; one word per cycle while ready_in is held high.
// Backpressure: valid/ready handshake; data_out, valid_out and last_out hold steady while valid_out && !ready_in.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   rate_input                    squeezed block, bit 0 leaves first
//   operation_mode_in             0 = SHAKE128 (21 words), else SHAKE256 (17 words)
//   output_size_in                message length in bits, sampled on a message's first block
//   output_buffer_we              block write strobe
//   last_output_block_wr          written block is the last of the message
//   output_buffer_available_clr   producer claims the buffer
//   output_buffer_available       buffer empty and writable
//   data_out, valid_out,
//   ready_in, last_out            word stream toward the consumer
module output_stage #(
  parameter int WORD_W        = 64,
  parameter int RATE_SHAKE128 = 1344
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RATE_SHAKE128-1:0] rate_input,
  input  logic [1:0]               operation_mode_in,
  input  logic [31:0]              output_size_in,
  input  logic                     output_buffer_we,
  input  logic                     last_output_block_wr,
  input  logic                     output_buffer_available_clr,
  output logic                     output_buffer_available,
  output logic [WORD_W-1:0]        data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic                     last_out
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [RATE_SHAKE128-1:0] shreg_q, shreg_d;
  logic [4:0]               word_cnt_q, word_cnt_d;
  logic [31:0]              remaining_q, remaining_d;
  logic                     last_blk_q, last_blk_d;
  logic                     msg_start_q, msg_start_d;
  logic                     avail_q, avail_d;

  logic                     xfer;
  logic                     set_avail;
  logic [31:0]              eff_rem;
  logic [31:0]              step;
  logic [WORD_W-1:0]        data_mask;

  assign valid_out               = (state_q == DRAIN);
  assign last_out                = valid_out && (remaining_q <= 32'(WORD_W));
  assign output_buffer_available = avail_q;
  assign xfer                    = valid_out && ready_in;

  // Bits at or beyond the remaining message length read as zero.
  always_comb begin
    data_mask = '0;
    for (int b = 0; b < WORD_W; b++) begin
      data_mask[b] = (remaining_q > $unsigned(b));
    end
  end

  assign data_out = shreg_q[WORD_W-1:0] & data_mask;
  assign step     = (remaining_q < 32'(WORD_W)) ? remaining_q : 32'(WORD_W);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    word_cnt_d  = word_cnt_q;
    remaining_d = remaining_q;
    last_blk_d  = last_blk_q;
    msg_start_d = msg_start_q;
    set_avail   = 1'b0;
    eff_rem     = msg_start_q ? output_size_in : remaining_q;

    case (state_q)
      IDLE: begin
        if (output_buffer_we) begin
          shreg_d     = rate_input;
          word_cnt_d  = (operation_mode_in == 2'd0) ? 5'd21 : 5'd17;
          last_blk_d  = last_output_block_wr;
          remaining_d = eff_rem;
          msg_start_d = 1'b0;
          if (eff_rem == 32'd0) begin
            // Nothing left to emit: drop the block on the spot. A dropped
            // last block still closes the message so the next one reloads.
            set_avail   = 1'b1;
            msg_start_d = last_output_block_wr;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Writes arriving here are a producer error and are ignored.
        if (xfer) begin
          shreg_d     = shreg_q >> WORD_W;
          word_cnt_d  = word_cnt_q - 5'd1;
          remaining_d = remaining_q - step;
          // Block ends on the message's final word (tail words dropped) or
          // on the block's own final word, whichever comes first.
          if (last_out || (word_cnt_q == 5'd1)) begin
            state_d   = IDLE;
            set_avail = 1'b1;
            if (last_blk_q) begin
              msg_start_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Set has priority over the producer's claim.
    avail_d = avail_q;
    if (output_buffer_available_clr) avail_d = 1'b0;
    if (set_avail)                   avail_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      word_cnt_q  <= '0;
      remaining_q <= '0;
      last_blk_q  <= 1'b0;
      msg_start_q <= 1'b1;
      avail_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      word_cnt_q  <= word_cnt_d;
      remaining_q <= remaining_d;
      last_blk_q  <= last_blk_d;
      msg_start_q <= msg_start_d;
      avail_q     <= avail_d;
    end
  end

endmodule

// File: tb/tb_output_stage.sv
module tb_output_stage;

  logic          clk;
  logic          rst;
  logic [1343:0] rate_input;
  logic [1:0]    operation_mode_in;
  logic [31:0]   output_size_in;
  logic          output_buffer_we;
  logic          last_output_block_wr;
  logic          output_buffer_available_clr;
  logic          output_buffer_available;
  logic [63:0]   data_out;
  logic          valid_out;
  logic          ready_in;
  logic          last_out;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  output_stage #(.WORD_W(64), .RATE_SHAKE128(1344)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .rate_input                  (rate_input),
    .operation_mode_in           (operation_mode_in),
    .output_size_in              (output_size_in),
    .output_buffer_we            (output_buffer_we),
    .last_output_block_wr        (last_output_block_wr),
    .output_buffer_available_clr (output_buffer_available_clr),
    .output_buffer_available     (output_buffer_available),
    .data_out                    (data_out),
    .valid_out                   (valid_out),
    .ready_in                    (ready_in),
    .last_out                    (last_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] pat(input int b, input int i);
    return {8'(b), 24'hC0FFEE, 32'(i * 7 + 1)};
  endfunction

  function automatic logic [1343:0] make_rate(input int b);
    logic [1343:0] r;
    r = '0;
    for (int i = 0; i < 21; i++) r[i*64 +: 64] = pat(b, i);
    return r;
  endfunction

  function automatic logic [63:0] mask(input int n);
    logic [63:0] m;
    for (int j = 0; j < 64; j++) m[j] = (j < n);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle block write, claiming the buffer in the same cycle.
  task automatic write_block(input int b, input logic [1:0] mode, input logic [31:0] size, input logic last);
    rate_input                  = make_rate(b);
    operation_mode_in           = mode;
    output_size_in              = size;
    last_output_block_wr        = last;
    output_buffer_we            = 1'b1;
    output_buffer_available_clr = 1'b1;
    tick();
    output_buffer_we            = 1'b0;
    output_buffer_available_clr = 1'b0;
    last_output_block_wr        = 1'b0;
  endtask

  // Checks the presented word then lets it transfer (ready_in assumed 1).
  task automatic expect_word(input string tag, input int b, input int i, input logic exp_last, input int nbits);
    chk({tag, "_vld"}, {63'd0, valid_out}, 64'd1);
    chk({tag, "_dat"}, data_out, pat(b, i) & mask(nbits));
    chk({tag, "_lst"}, {63'd0, last_out}, {63'd0, exp_last});
    tick();
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_vld0"}, {63'd0, valid_out}, 64'd0);
    chk({tag, "_av1"}, {63'd0, output_buffer_available}, 64'd1);
  endtask

  initial begin
    int  k;
    logic xf;
    rst = 1'b1;
    rate_input = '0;
    operation_mode_in = 2'd0;
    output_size_in = '0;
    output_buffer_we = 1'b0;
    last_output_block_wr = 1'b0;
    output_buffer_available_clr = 1'b0;
    ready_in = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_av", {63'd0, output_buffer_available}, 64'd1);
    chk("rst_vld", {63'd0, valid_out}, 64'd0);
    chk("rst_lst", {63'd0, last_out}, 64'd0);
    chk("rst_dat", data_out, 64'd0);

    // SHAKE128, 256 bits, single last block: 4 words, last on the 4th
    write_block(1, 2'd0, 32'd256, 1'b1);
    chk("t1_av0", {63'd0, output_buffer_available}, 64'd0);
    for (int i = 0; i < 4; i++) expect_word("t1", 1, i, (i == 3), 64);
    expect_idle("t1_end");

    // SHAKE256, 2000 bits over two blocks: 17 full words then 15, last partial (16 bits)
    write_block(2, 2'd1, 32'd2000, 1'b0);
    for (int i = 0; i < 17; i++) expect_word("t2a", 2, i, 1'b0, 64);
    expect_idle("t2a_end");
    write_block(3, 2'd1, 32'd2000, 1'b1);
    for (int i = 0; i < 15; i++) expect_word("t2b", 3, i, (i == 14), (i == 14) ? 16 : 64);
    expect_idle("t2b_end");

    // SHAKE128 1344 bits with ready toggling: 21 transfers, stable while stalled
    write_block(4, 2'd0, 32'd1344, 1'b1);
    k = 0;
    for (int cyc = 0; cyc < 100 && k < 21; cyc++) begin
      chk("t3_vld", {63'd0, valid_out}, 64'd1);
      chk("t3_dat", data_out, pat(4, k));
      chk("t3_lst", {63'd0, last_out}, {63'd0, (k == 20)});
      ready_in = (cyc % 2 == 1);
      xf = valid_out && ready_in;
      tick();
      if (xf) k++;
    end
    chk("t3_cnt", 64'(k), 64'd21);
    ready_in = 1'b1;
    expect_idle("t3_end");

    // output_size 0: no word, buffer released one cycle after the write
    write_block(5, 2'd0, 32'd0, 1'b1);
    expect_idle("t4");

    // Message ends on last_out of a non-last block; following blocks dropped
    write_block(6, 2'd0, 32'd128, 1'b0);
    expect_word("t5", 6, 0, 1'b0, 64);
    expect_word("t5", 6, 1, 1'b1, 64);
    expect_idle("t5_end");
    write_block(7, 2'd0, 32'd500, 1'b0);
    expect_idle("t5_drop1");
    write_block(8, 2'd0, 32'd500, 1'b1);
    expect_idle("t5_drop2");

    // Last-flagged block ends the message with remaining > 0, no last_out
    write_block(9, 2'd3, 32'd5000, 1'b1);
    for (int i = 0; i < 17; i++) expect_word("t6", 9, i, 1'b0, 64);
    expect_idle("t6_end");
    write_block(10, 2'd0, 32'd64, 1'b1);
    expect_word("t6_new", 10, 0, 1'b1, 64);
    expect_idle("t6_new_end");

    // Reset after word 5 of a block, then a fresh message reloads its size
    write_block(11, 2'd0, 32'd1344, 1'b0);
    for (int i = 0; i < 5; i++) expect_word("t7", 11, i, 1'b0, 64);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_idle("t7_rst");
    write_block(12, 2'd0, 32'd128, 1'b1);
    expect_word("t7_new", 12, 0, 1'b0, 64);
    expect_word("t7_new", 12, 1, 1'b1, 64);
    expect_idle("t7_new_end");

    // Write during DRAIN ignored; clr coincident with the final transfer
    write_block(13, 2'd0, 32'd128, 1'b1);
    ready_in = 1'b0;
    rate_input = make_rate(14);
    output_buffer_we = 1'b1;
    tick();
    output_buffer_we = 1'b0;
    chk("t8_hold_vld", {63'd0, valid_out}, 64'd1);
    chk("t8_hold_dat", data_out, pat(13, 0));
    ready_in = 1'b1;
    expect_word("t8", 13, 0, 1'b0, 64);
    output_buffer_available_clr = 1'b1;
    expect_word("t8", 13, 1, 1'b1, 64);
    output_buffer_available_clr = 1'b0;
    expect_idle("t8_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/output_stage.md
OUTPUT_STAGE -- requirements
Module: output_stage

Interface
REQ-001 Parameter WORD_W, default 64, width in bits of one output word.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 rate_input  in  RATE_SHAKE128  squeezed block from the permute stage; bit 0 is the first output bit.
REQ-005 operation_mode_in  in  2  mode of the block: 0 = SHAKE128 (21 words), any other value = SHAKE256 (17 words).
REQ-006 output_size_in  in  32  requested output length of the message, in bits.
REQ-007 output_buffer_we  in  1  permute stage writes a block this cycle.
REQ-008 last_output_block_wr  in  1  the block written this cycle is the last block of the message.
REQ-009 output_buffer_available_clr  in  1  permute stage claims the buffer.
REQ-010 output_buffer_available  out  1  buffer is empty and may be written.
REQ-011 data_out  out  WORD_W  output word.
REQ-012 valid_out  out  1  data_out is valid.
REQ-013 ready_in  in  1  downstream accepts the word; a transfer occurs when valid_out && ready_in.
REQ-014 last_out  out  1  the current word is the final word of the message.

Function
REQ-015 States: IDLE (buffer empty) and DRAIN (buffer holds a block); reset enters IDLE.
REQ-016 output_buffer_available SHALL be 1 in IDLE and SHALL be cleared by output_buffer_available_clr.
REQ-017 output_buffer_available SHALL be set the cycle after the block's final transfer or the block's discard.
REQ-018 If a set and output_buffer_available_clr occur in the same cycle, the set SHALL win.
REQ-019 On output_buffer_we in IDLE, the stage SHALL capture rate_input, the block word count (21 or 17) from operation_mode_in, and last_output_block_wr, then enter DRAIN.
REQ-020 output_buffer_we in DRAIN is a protocol error; the stage SHALL ignore it and keep the held block.
REQ-021 Message-start flag: set at reset and set after a message completes.
REQ-022 On the first write of a message, the remaining-bit counter SHALL be loaded from output_size_in and the message-start flag cleared; later blocks of the message do not reload the counter.
REQ-023 Latency: valid_out SHALL rise in the cycle after output_buffer_we.
REQ-024 data_out SHALL be the low WORD_W bits of a shift register, shifted right by WORD_W on each transfer (word 0 = bits [WORD_W-1:0]).
REQ-025 On each transfer the stage SHALL decrement the word counter and decrement the remaining-bit counter by min(WORD_W, remaining).
REQ-026 When remaining < WORD_W, data_out bits [WORD_W-1:remaining] SHALL read 0.
REQ-027 last_out SHALL be 1 with valid_out only when remaining <= WORD_W.
REQ-028 The message SHALL end when its last_out word transfers; remaining words of that block SHALL be discarded with no handshake, and the stage returns to IDLE.
REQ-029 A block SHALL end after its final word (word count reaches 0) transfers.
REQ-030 If that block was flagged last, the message SHALL end even if remaining > 0; no last_out word is emitted in that case.
REQ-031 After the message ends, a non-last block arriving with remaining = 0 SHALL be discarded in one cycle with valid_out held 0.
REQ-032 output_size_in = 0 on the first block: no word is emitted; the block is discarded; output_buffer_available is set the next cycle.
REQ-033 valid_out, data_out and last_out SHALL be held stable while valid_out && !ready_in.
REQ-034 Counter widths: word counter 5 bits; remaining counter 32 bits, with no underflow below 0.

Reset
REQ-035 When rst=1 at a clock edge, the stage SHALL enter IDLE from any state.
REQ-036 On reset: output_buffer_available=1, valid_out=0, last_out=0, data_out=0, all counters 0, message-start flag=1.
REQ-037 On reset, any held block SHALL be dropped.

Verification
REQ-038 SHAKE128, output_size 256, one block flagged last, ready_in=1 -> 4 words on consecutive cycles, last_out on the 4th, available=1 one cycle later.
REQ-039 SHAKE256, output_size 2000, blocks flagged last on the 2nd -> 17 words, then 15 words; the 15th word has bits [63:16] zero and last_out=1.
REQ-040 ready_in toggling 1/0 during a SHAKE128 block of 1344 bits -> 21 transfers; data stable while stalled; no word lost or duplicated.
REQ-041 output_size 0 -> valid_out stays 0; available returns to 1 one cycle after output_buffer_we.
REQ-042 rst asserted after word 5 of a block -> next cycle valid_out=0, available=1; a new message then reloads output_size_in.
REQ-043 available_clr and a block's final transfer in the same cycle -> available=1 the next cycle.
